instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the decode/control path. Owns the PC and issues in-order word

---
 rtl/riscv_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 39 +++
 rtl/instr_fetch_unit.sv | 70 +++++++
 tb/tb_instr_fetch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch constants, fetch FSM states and instruction field helpers
package riscv_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_e;
  function automatic logic [6:0] op_of(input logic [31:0] i);
    return i[6:0];
  endfunction
  function automatic logic [2:0] funct3_of(input logic [31:0] i);
    return i[14:12];
  endfunction
  function automatic logic funct7b5_of(input logic [31:0] i);
    return i[30];
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry sync FIFO (push_i/din_i in, pop_i/dout_o out, clear_i flush, count_o occupancy)
module fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= inc(wr_q);
      if (pop_i) rd_q <= inc(rd_q);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
  assign dout_o = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing in-order imem reads, buffering words and handing instr/pc to decode
// imem_req_*/imem_addr: request side; imem_rsp_*: in-order responses; instr_*: decode handshake; pc_src/pc_target: redirect
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target
);
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, tag_pc, head_pc;
  logic [31:0] head_instr;
  logic [CW-1:0] outstanding, count, out_next;
  logic [CW:0] credits_used;
  logic req_fire, pop, push, redirect, unused_pc_lsbs;
  assign unused_pc_lsbs = ^pc_target[1:0];
  assign credits_used = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = state_q == RUN && credits_used < (CW + 1)'(DEPTH);
  assign imem_addr = fetch_pc_q;
  assign req_fire = imem_req_valid & imem_req_ready;
  assign instr_valid = state_q == RUN && count != '0;
  assign pop = instr_valid & instr_ready;
  assign redirect = pop & pc_src;
  assign push = imem_rsp_valid && state_q == RUN && !redirect;
  // The tag FIFO occupancy is the outstanding count; in FLUSH it is also the number of responses left to drop.
  assign out_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  assign instr = instr_valid ? head_instr : '0;
  assign instr_pc = instr_valid ? head_pc : '0;
  assign instr_pc_plus4 = instr_valid ? head_pc + XLEN'(4) : '0;
  fetch_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tags (
    .clk(clk), .reset(reset), .push_i(req_fire), .pop_i(imem_rsp_valid), .clear_i(1'b0),
    .din_i(fetch_pc_q), .dout_o(tag_pc), .count_o(outstanding)
  );
  fetch_fifo #(.W(XLEN + 32), .DEPTH(DEPTH)) u_words (
    .clk(clk), .reset(reset), .push_i(push), .pop_i(pop), .clear_i(redirect),
    .din_i({tag_pc, imem_rsp_data}), .dout_o({head_pc, head_instr}), .count_o(count)
  );
  always_comb begin
    fetch_pc_d = redirect ? {pc_target[XLEN-1:2], 2'b00} : req_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    state_d = state_q == BOOT ? RUN :
              redirect ? (out_next != '0 ? FLUSH : RUN) :
              (state_q == FLUSH && out_next == '0) ? RUN : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end
  a_rsp_needs_req: assert property (@(posedge clk) disable iff (reset) imem_rsp_valid |-> outstanding != '0);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench with an in-order latency-configurable imem model
module tb_instr_fetch_unit;
  logic clk = 0, reset = 1;
  logic imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0, instr_valid, instr_ready = 0, pc_src = 0;
  logic [31:0] imem_addr, imem_rsp_data = 0, instr, instr_pc, instr_pc_plus4, pc_target = 0;
  always #5 clk = ~clk;
  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .instr_pc_plus4(instr_pc_plus4), .pc_src(pc_src), .pc_target(pc_target)
  );
  int checks = 0, errors = 0, cyc = 0, lat = 1, hold_until = 0;
  int first_valid, delivered, req_cnt, n_redirect, stale, dropped, wrap_seen, redir_pend, rsp_in_redirect;
  logic [31:0] mq_addr[$], exp_q[$], br_pc[$], br_tgt[$];
  int mq_due[$];
  logic [31:0] exp_req, last_pc;
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction
  task automatic fill_exp(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(start + 32'(4 * i));
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; instr_ready = 0; pc_src = 0; pc_target = 0;
    mq_addr.delete(); mq_due.delete(); br_pc.delete(); br_tgt.delete();
    lat = 1; hold_until = 0; stale = 0; dropped = 0; first_valid = -1; delivered = 0; req_cnt = 0;
    n_redirect = 0; wrap_seen = 0; redir_pend = 0; rsp_in_redirect = 0; last_pc = 0;
    exp_req = 0; fill_exp(0); cyc = 0;
    @(negedge clk);
    checks += 5;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid: got %b expected 0", instr_valid); end
    if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", instr); end
    if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc: got %h expected 0", instr_pc); end
    if (instr_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc_plus4: got %h expected 0", instr_pc_plus4); end
    reset = 0;
  endtask
  task automatic step();
    logic [31:0] hpc;
    @(negedge clk);
    cyc++;
    imem_req_ready = 1;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data = word_of(mq_addr.pop_front());
      void'(mq_due.pop_front());
      if (stale > 0) begin stale--; dropped++; end
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data = 0;
    end
    instr_ready = cyc >= hold_until;
    pc_src = br_pc.size() > 0 && instr_valid && instr_pc == br_pc[0];
    pc_target = br_tgt.size() > 0 ? br_tgt[0] : 32'h0;
    if (imem_req_valid) begin
      checks++;
      if (imem_addr !== exp_req) begin errors++; $display("FAIL req_addr: got %h expected %h (cycle %0d)", imem_addr, exp_req, cyc); end
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + lat);
      exp_req += 4;
      req_cnt++;
    end
    checks++;
    if (instr_valid && stale > 0) begin errors++; $display("FAIL wrong_path_valid: got instr_valid=1 expected 0 (cycle %0d)", cyc); end
    if (instr_valid && first_valid < 0) first_valid = cyc;
    if (instr_valid && instr_ready) begin
      delivered++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL scoreboard_empty: got pc %h expected no delivery", instr_pc);
      end else begin
        hpc = exp_q.pop_front();
        last_pc = hpc;
        if (hpc == 32'hFFFF_FFFC) wrap_seen++;
        checks += 2;
        if (instr_pc !== hpc) begin errors++; $display("FAIL instr_pc: got %h expected %h", instr_pc, hpc); end
        if (instr !== word_of(hpc)) begin errors++; $display("FAIL instr: got %h expected %h", instr, word_of(hpc)); end
        if (instr_pc_plus4 !== hpc + 32'd4) begin errors++; $display("FAIL pc_plus4: got %h expected %h", instr_pc_plus4, hpc + 32'd4); end
      end
      if (pc_src) begin
        n_redirect++;
        redir_pend = mq_addr.size() + int'(imem_rsp_valid);
        if (imem_rsp_valid) rsp_in_redirect = 1;
        exp_req = pc_target & 32'hFFFF_FFFC;
        fill_exp(exp_req);
        stale = mq_addr.size();
        void'(br_pc.pop_front());
        void'(br_tgt.pop_front());
      end
    end
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic test_reset();
    do_reset();
    step();
    checks += 2;
    if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL boot_to_run_req: got %b expected 1", imem_req_valid); end
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL boot_instr_valid: got %b expected 0", instr_valid); end
  endtask
  task automatic test_sequential();
    do_reset();
    run(20);
    checks += 2;
    if (first_valid != 3) begin errors++; $display("FAIL first_valid_cycle: got %0d expected 3", first_valid); end
    if (delivered < 10) begin errors++; $display("FAIL seq_delivered: got %0d expected >=10", delivered); end
  endtask
  task automatic test_stall();
    do_reset();
    hold_until = 11;
    run(10);
    checks += 3;
    if (req_cnt != 2) begin errors++; $display("FAIL stall_reqs: got %0d expected 2", req_cnt); end
    if (delivered != 0) begin errors++; $display("FAIL stall_delivered: got %0d expected 0", delivered); end
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", instr_valid); end
    run(15);
    checks++;
    if (delivered < 8) begin errors++; $display("FAIL stall_release: got %0d expected >=8", delivered); end
  endtask
  task automatic test_branch();
    do_reset();
    br_pc.push_back(32'h8); br_tgt.push_back(32'h40);
    run(20);
    checks += 3;
    if (n_redirect != 1) begin errors++; $display("FAIL br_redirects: got %0d expected 1", n_redirect); end
    if (redir_pend < 1) begin errors++; $display("FAIL br_outstanding: got %0d expected >=1", redir_pend); end
    if (last_pc < 32'h48) begin errors++; $display("FAIL br_progress: got %h expected >=00000048", last_pc); end
  endtask
  task automatic test_jump_flush();
    do_reset();
    lat = 3;
    br_pc.push_back(32'h0); br_tgt.push_back(32'h200);
    br_pc.push_back(32'h204); br_tgt.push_back(32'h300);
    run(30);
    checks += 4;
    if (n_redirect != 2) begin errors++; $display("FAIL jmp_redirects: got %0d expected 2", n_redirect); end
    if (rsp_in_redirect != 1) begin errors++; $display("FAIL jmp_rsp_same_cycle: got %0d expected 1", rsp_in_redirect); end
    if (dropped < 1) begin errors++; $display("FAIL jmp_flush_drops: got %0d expected >=1", dropped); end
    if (last_pc < 32'h300 || last_pc >= 32'h400) begin errors++; $display("FAIL jmp_progress: got %h expected 0000030x", last_pc); end
  endtask
  task automatic test_target_wrap();
    do_reset();
    br_pc.push_back(32'h4); br_tgt.push_back(32'h43);
    br_pc.push_back(32'h48); br_tgt.push_back(32'hFFFF_FFF8);
    run(40);
    checks += 3;
    if (n_redirect != 2) begin errors++; $display("FAIL wrap_redirects: got %0d expected 2", n_redirect); end
    if (wrap_seen != 1) begin errors++; $display("FAIL wrap_seen: got %0d expected 1", wrap_seen); end
    if (last_pc >= 32'h40) begin errors++; $display("FAIL wrap_progress: got %h expected <00000040", last_pc); end
  endtask
  task automatic test_reset_flush();
    do_reset();
    lat = 5;
    hold_until = 8;
    br_pc.push_back(32'h4); br_tgt.push_back(32'h80);
    run(9);
    checks++;
    if (stale < 1) begin errors++; $display("FAIL flush_pending: got %0d expected >=1", stale); end
    do_reset();
    run(8);
    checks += 2;
    if (delivered < 3) begin errors++; $display("FAIL restart_delivered: got %0d expected >=3", delivered); end
    if (last_pc >= 32'h20) begin errors++; $display("FAIL restart_pc: got %h expected <00000020", last_pc); end
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_flush();
    test_target_wrap();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
